activity_gen_lanes: RTL and testbench

//   Parametrised multi-lane switching-activity generator; successor to fixed single-inverter stimulus cells.

---
 rtl/activity_gen_pkg.sv | 14 +
 rtl/activity_lane.sv | 43 ++++
 rtl/activity_gen_lanes.sv | 103 ++++++++++
 tb/tb_activity_gen_lanes.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/activity_gen_pkg.sv
// Shared types and helpers for the multi-lane switching-activity generator.
package activity_gen_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Lane index width, never narrower than one bit (a single-lane build still has a port).
  function automatic int lane_idx_w(input int num_lanes);
    return (num_lanes > 1) ? $clog2(num_lanes) : 1;
  endfunction

endpackage

// File: rtl/activity_lane.sv
// One activity lane: programmable half-period square wave, held low while disabled or cleared.
module activity_lane #(
  parameter int PERIOD_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [PERIOD_W-1:0] wr_period,
  input  logic                run,
  input  logic                clear,
  output logic                y
);

  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] cnt_q;
  logic                y_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      period_q <= '0;
    end else if (wr_en) begin
      period_q <= wr_period;
    end
  end

  // A zero period disables the lane, so counter and output stay parked at 0.
  always_ff @(posedge clk) begin
    if (rst || clear || (period_q == '0)) begin
      cnt_q <= '0;
      y_q   <= 1'b0;
    end else if (run) begin
      if (cnt_q == (period_q - PERIOD_W'(1))) begin
        cnt_q <= '0;
        y_q   <= ~y_q;
      end else begin
        cnt_q <= cnt_q + PERIOD_W'(1);
      end
    end
  end

  assign y = y_q;

endmodule

// File: rtl/activity_gen_lanes.sv
// Multi-lane switching-activity generator: config port, start/stop run FSM,
// burst-length run counter and one square-wave lane per output bit.
module activity_gen_lanes
  import activity_gen_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int PERIOD_W  = 8,
  parameter int BURST_W   = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cfg_valid,
  output logic                                cfg_ready,
  input  logic [lane_idx_w(NUM_LANES)-1:0]    cfg_lane,
  input  logic [PERIOD_W-1:0]                 cfg_period,
  input  logic                                start,
  input  logic                                stop,
  input  logic [BURST_W-1:0]                  burst_len,
  output logic                                busy,
  output logic                                done,
  output logic [BURST_W-1:0]                  run_cycles,
  output logic [NUM_LANES-1:0]                y
);

  localparam int LANE_IDX_W = lane_idx_w(NUM_LANES);

  state_e             state_q, state_d;
  logic               done_q, done_d;
  logic [BURST_W-1:0] burst_q;
  logic [BURST_W-1:0] run_cycles_q;
  logic [BURST_W-1:0] run_cycles_inc;
  logic               cfg_fire;
  logic               lane_run;
  logic               lane_clear;

  assign run_cycles_inc = run_cycles_q + BURST_W'(1);

  // Burst completion outranks stop so a coincident stop still reports done.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) state_d = ST_RUN;
      end
      ST_RUN: begin
        if ((burst_q != '0) && (run_cycles_inc == burst_q)) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (stop) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      burst_q      <= '0;
      run_cycles_q <= '0;
    end else if ((state_q == ST_IDLE) && (state_d == ST_RUN)) begin
      burst_q      <= burst_len;
      run_cycles_q <= '0;
    end else if (state_q == ST_RUN) begin
      run_cycles_q <= run_cycles_inc;
    end
  end

  assign cfg_ready  = (state_q == ST_IDLE) && !rst;
  assign cfg_fire   = cfg_valid && cfg_ready;
  assign lane_run   = (state_q == ST_RUN);
  // Lanes are zeroed on every edge that lands in IDLE, including the last RUN edge.
  assign lane_clear = (state_d == ST_IDLE);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    activity_lane #(
      .PERIOD_W (PERIOD_W)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (cfg_fire && (cfg_lane == LANE_IDX_W'(i))),
      .wr_period (cfg_period),
      .run       (lane_run),
      .clear     (lane_clear),
      .y         (y[i])
    );
  end

  assign busy       = (state_q == ST_RUN);
  assign done       = done_q;
  assign run_cycles = run_cycles_q;

endmodule

// File: tb/tb_activity_gen_lanes.sv
// Scoreboard bench for activity_gen_lanes: a per-cycle reference model predicts
// every output, a negedge monitor pops and compares.
module tb_activity_gen_lanes;

  localparam int NL = 5;
  localparam int PW = 8;
  localparam int BW = 16;
  localparam int LW = 3;

  logic          clk;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [LW-1:0] cfg_lane;
  logic [PW-1:0] cfg_period;
  logic          start;
  logic          stop;
  logic [BW-1:0] burst_len;
  logic          busy;
  logic          done;
  logic [BW-1:0] run_cycles;
  logic [NL-1:0] y;

  activity_gen_lanes #(
    .NUM_LANES (NL),
    .PERIOD_W  (PW),
    .BURST_W   (BW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_lane   (cfg_lane),
    .cfg_period (cfg_period),
    .start      (start),
    .stop       (stop),
    .burst_len  (burst_len),
    .busy       (busy),
    .done       (done),
    .run_cycles (run_cycles),
    .y          (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NL-1:0] y;
    logic          busy;
    logic          done;
    logic          cfg_ready;
    logic [BW-1:0] rc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: run mode, edges elapsed in the run, burst target, periods.
  bit m_valid = 0;
  bit m_run   = 0;
  bit m_done  = 0;
  int m_t     = 0;
  int m_b     = 0;
  int m_rc    = 0;
  int m_per[NL];

  function automatic logic [NL-1:0] model_y();
    logic [NL-1:0] v;
    v = '0;
    for (int i = 0; i < NL; i++)
      if (m_run && m_per[i] > 0) v[i] = ((m_t / m_per[i]) % 2) == 1;
    return v;
  endfunction

  task automatic model_step(input bit r, input bit cv, input int cl, input int cp,
                            input bit st, input bit sp, input int bl);
    if (r) begin
      m_run = 0; m_done = 0; m_t = 0; m_b = 0; m_rc = 0;
      for (int i = 0; i < NL; i++) m_per[i] = 0;
    end else if (!m_run) begin
      m_done = 0;
      if (cv && cl < NL) m_per[cl] = cp;
      if (st && !sp) begin
        m_run = 1; m_t = 0; m_rc = 0; m_b = bl;
      end
    end else begin
      m_t    = m_t + 1;
      m_rc   = (m_rc + 1) % (1 << BW);
      m_done = 0;
      if (m_b != 0 && m_t == m_b) begin
        m_done = 1; m_run = 0;
      end else if (sp) begin
        m_run = 0;
      end
    end
  endtask

  task automatic drive(input bit r, input bit cv, input int cl, input int cp,
                       input bit st, input bit sp, input int bl);
    exp_t e;
    @(posedge clk);
    #1;
    rst        = r;
    cfg_valid  = cv;
    cfg_lane   = cl[LW-1:0];
    cfg_period = cp[PW-1:0];
    start      = st;
    stop       = sp;
    burst_len  = bl[BW-1:0];
    if (m_valid) begin
      e.y         = model_y();
      e.busy      = m_run;
      e.done      = m_done;
      e.cfg_ready = !m_run && !r;
      e.rc        = m_rc[BW-1:0];
      q.push_back(e);
    end
    model_step(r, cv, cl, cp, st, sp, bl);
    if (r) m_valid = 1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  exp_t me;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      me = q.pop_front();
      chk("y", longint'(y), longint'(me.y));
      chk("busy", longint'(busy), longint'(me.busy));
      chk("done", longint'(done), longint'(me.done));
      chk("cfg_ready", longint'(cfg_ready), longint'(me.cfg_ready));
      chk("run_cycles", longint'(run_cycles), longint'(me.rc));
    end
  end

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_lane = '0; cfg_period = '0;
    start = 1'b0; stop = 1'b0; burst_len = '0;

    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Basic burst: lane periods 2,3,0,1,5 then B=12.
    drive(0, 1, 0, 2, 0, 0, 0);
    drive(0, 1, 1, 3, 0, 0, 0);
    drive(0, 1, 2, 0, 0, 0, 0);
    drive(0, 1, 3, 1, 0, 0, 0);
    drive(0, 1, 4, 5, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 12);
    idle(15);

    // Config attempts during RUN are ignored.
    drive(0, 0, 0, 0, 1, 0, 10);
    drive(0, 1, 0, 9, 0, 0, 0);
    drive(0, 1, 1, 7, 1, 0, 3);
    drive(0, 1, 3, 4, 0, 0, 0);
    idle(10);
    drive(0, 0, 0, 0, 1, 0, 8);
    idle(10);

    // start and stop together stay IDLE; stop on cycle 5 of B=20.
    drive(0, 0, 0, 0, 1, 1, 5);
    idle(3);
    drive(0, 0, 0, 0, 1, 0, 20);
    idle(4);
    drive(0, 0, 0, 0, 0, 1, 0);
    idle(3);

    // Stop coinciding with burst completion.
    drive(0, 0, 0, 0, 1, 0, 4);
    idle(3);
    drive(0, 0, 0, 0, 0, 1, 0);
    idle(2);

    // Reset mid-run, then a run with no configuration.
    drive(0, 0, 0, 0, 1, 0, 30);
    idle(3);
    drive(1, 1, 0, 4, 1, 0, 0);
    idle(2);
    drive(0, 0, 0, 0, 1, 0, 10);
    idle(12);

    // Out-of-range lane indices are accepted but change nothing.
    drive(0, 1, 0, 2, 0, 0, 0);
    drive(0, 1, 1, 3, 0, 0, 0);
    drive(0, 1, 5, 7, 0, 0, 0);
    drive(0, 1, 7, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 16);
    idle(18);

    // Randomised traffic.
    for (int k = 0; k < 600; k++) begin
      drive(($urandom_range(0, 99) < 1),
            ($urandom_range(0, 99) < 30),
            int'($urandom_range(0, 7)),
            int'($urandom_range(0, 6)),
            ($urandom_range(0, 99) < 12),
            ($urandom_range(0, 99) < 4),
            int'($urandom_range(0, 40)));
    end
    idle(45);
    drive(0, 0, 0, 0, 0, 1, 0);
    idle(2);

    // Free-run across the run_cycles wrap.
    drive(0, 1, 2, 0, 0, 0, 0);
    drive(0, 1, 3, 1, 0, 0, 0);
    drive(0, 1, 0, 3, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    idle(65540);
    drive(0, 0, 0, 0, 0, 1, 0);
    idle(3);

    repeat (3) @(posedge clk);
    chk("queue_drained", longint'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
